rca_wb_sequencer: RTL and testbench

Writeback sequencer sitting directly downstream of the reconfigurable-accelerator PR grid. After an accelerator invocation it drains each output-mode IO unit's FIFO, one result per unit, and issues those results in ascending IO-unit order over a single valid/ready register-file writeback port. It owns the grid's `io_fifo_pop` and `io_units_rst` controls. It reports completion, timeout and abort back to the issue logic.

---
 rtl/rca_wb_sequencer_if.sv | 40 ++++
 rtl/rca_wb_sequencer.sv | 165 ++++++++++++++++
 tb/tb_rca_wb_sequencer.sv | 342 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rca_wb_sequencer_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rca_wb_sequencer_if : control, grid IO-unit and writeback signals of the
//                       PR-grid writeback sequencer.      Rev 1.0
// ---------------------------------------------------------------------------
interface rca_wb_sequencer_if #(
  parameter int XLEN         = 32,
  parameter int NUM_IO_UNITS = 4
);
  logic                                 start;
  logic                                 abort;
  logic [NUM_IO_UNITS-1:0]              wb_unit_mask;
  logic [NUM_IO_UNITS-1:0][4:0]         wb_rd_addrs;
  logic [NUM_IO_UNITS-1:0][XLEN-1:0]    io_unit_data_out;
  logic [NUM_IO_UNITS-1:0]              io_unit_data_valid_out;
  logic [NUM_IO_UNITS-1:0]              io_fifo_pop;
  logic                                 io_units_rst;
  logic                                 wb_valid;
  logic [4:0]                           wb_rd;
  logic [XLEN-1:0]                      wb_data;
  logic                                 wb_ready;
  logic                                 busy;
  logic                                 done;
  logic                                 timeout_err;

  modport master (
    input  start, abort, wb_unit_mask, wb_rd_addrs,
    input  io_unit_data_out, io_unit_data_valid_out, wb_ready,
    output io_fifo_pop, io_units_rst, wb_valid, wb_rd, wb_data,
    output busy, done, timeout_err
  );

  modport slave (
    output start, abort, wb_unit_mask, wb_rd_addrs,
    output io_unit_data_out, io_unit_data_valid_out, wb_ready,
    input  io_fifo_pop, io_units_rst, wb_valid, wb_rd, wb_data,
    input  busy, done, timeout_err
  );
endinterface
`default_nettype wire

// File: rtl/rca_wb_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rca_wb_sequencer : drains one result per selected grid IO unit and writes
//                    them back in ascending unit order.    Rev 1.0
// ---------------------------------------------------------------------------
module rca_wb_sequencer #(
  parameter int XLEN           = 32,
  parameter int NUM_IO_UNITS   = 4,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic               clk,
  input  logic               rst,
  rca_wb_sequencer_if.master bus
);

  localparam int SEL_W = (NUM_IO_UNITS > 1) ? $clog2(NUM_IO_UNITS) : 1;
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_COLLECT = 3'd1,
    S_WB      = 3'd2,
    S_DONE    = 3'd3,
    S_FLUSH   = 3'd4
  } state_t;

  state_t                       state_q, state_d;
  logic [NUM_IO_UNITS-1:0]      pending_q, pending_d;
  logic [NUM_IO_UNITS-1:0][4:0] rd_q, rd_d;
  logic [SEL_W-1:0]             sel_q, sel_d;
  logic [XLEN-1:0]              data_q, data_d;
  logic [CNT_W-1:0]             cnt_q, cnt_d;
  logic                         err_q, err_d;

  logic [NUM_IO_UNITS-1:0]      fifo_pop;
  logic                         units_rst;
  logic                         wb_valid;
  logic [4:0]                   wb_rd;
  logic [XLEN-1:0]              wb_data;
  logic                         busy;
  logic                         done;
  logic                         timeout_err;
  logic                         sel_valid;
  logic [XLEN-1:0]              sel_data;

  function automatic logic [SEL_W-1:0] lowest_set(input logic [NUM_IO_UNITS-1:0] m);
    lowest_set = '0;
    for (int i = NUM_IO_UNITS - 1; i >= 0; i--) begin
      if (m[i]) lowest_set = SEL_W'(i);
    end
  endfunction

  assign sel_valid = bus.io_unit_data_valid_out[sel_q];
  assign sel_data  = bus.io_unit_data_out[sel_q];

  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q;
    rd_d        = rd_q;
    data_d      = data_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    fifo_pop    = '0;
    units_rst   = 1'b0;
    wb_valid    = 1'b0;
    wb_rd       = '0;
    wb_data     = '0;
    done        = 1'b0;
    timeout_err = 1'b0;
    busy        = (state_q != S_IDLE);

    case (state_q)
      S_IDLE: begin
        err_d = 1'b0;
        // abort wins over start here; the start is simply dropped
        if (bus.start && !bus.abort) begin
          pending_d = bus.wb_unit_mask;
          rd_d      = bus.wb_rd_addrs;
          cnt_d     = '0;
          state_d   = (bus.wb_unit_mask == '0) ? S_DONE : S_COLLECT;
        end
      end

      S_COLLECT: begin
        fifo_pop[sel_q] = sel_valid;
        if (sel_valid) data_d = sel_data;
        if (bus.abort) begin
          err_d   = 1'b0;
          state_d = S_FLUSH;
        end else if (sel_valid) begin
          state_d = S_WB;
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          state_d = S_FLUSH;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_WB: begin
        wb_valid = 1'b1;
        wb_rd    = rd_q[sel_q];
        wb_data  = data_q;
        if (bus.wb_ready) pending_d[sel_q] = 1'b0;
        // a handshake coinciding with abort is consumed, but the run still flushes
        if (bus.abort) begin
          err_d   = 1'b0;
          state_d = S_FLUSH;
        end else if (bus.wb_ready) begin
          cnt_d   = '0;
          state_d = (pending_d == '0) ? S_DONE : S_COLLECT;
        end
      end

      S_DONE: begin
        done      = 1'b1;
        units_rst = 1'b1;
        state_d   = S_IDLE;
      end

      S_FLUSH: begin
        units_rst   = 1'b1;
        timeout_err = err_q;
        err_d       = 1'b0;
        state_d     = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    sel_d = lowest_set(pending_d);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      pending_q <= '0;
      rd_q      <= '0;
      sel_q     <= '0;
      data_q    <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      rd_q      <= rd_d;
      sel_q     <= sel_d;
      data_q    <= data_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
    end
  end

  assign bus.io_fifo_pop  = fifo_pop;
  assign bus.io_units_rst = units_rst;
  assign bus.wb_valid     = wb_valid;
  assign bus.wb_rd        = wb_rd;
  assign bus.wb_data      = wb_data;
  assign bus.busy         = busy;
  assign bus.done         = done;
  assign bus.timeout_err  = timeout_err;

endmodule
`default_nettype wire

// File: tb/tb_rca_wb_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_rca_wb_sequencer : randomized and directed sequences against a
//                       transaction-level model with per-unit FIFOs. Rev 1.0
// ---------------------------------------------------------------------------
module tb_rca_wb_sequencer;
  localparam int XLEN = 32;
  localparam int N    = 4;
  localparam int TO   = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rca_wb_sequencer_if #(.XLEN(XLEN), .NUM_IO_UNITS(N)) bus ();

  rca_wb_sequencer #(
    .XLEN(XLEN), .NUM_IO_UNITS(N), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // IO-unit FIFO model
  logic [31:0] fifo_mem [N][8];
  int          fifo_cnt [N];

  function automatic void push(input int u, input logic [31:0] d);
    if (fifo_cnt[u] < 8) begin
      fifo_mem[u][fifo_cnt[u]] = d;
      fifo_cnt[u]++;
    end
  endfunction

  function automatic void drive_fifo();
    for (int u = 0; u < N; u++) begin
      bus.io_unit_data_valid_out[u] = (fifo_cnt[u] > 0);
      bus.io_unit_data_out[u]       = (fifo_cnt[u] > 0) ? fifo_mem[u][0] : (32'hDEAD_0000 | u);
    end
  endfunction

  // observations of the current sequence
  int          cyc = 0;
  int          obs_n, wbv_n, done_n, terr_n, urst_n;
  int          done_cyc, terr_cyc, urst_cyc, hs_cyc;
  int          pop_cnt [N];
  logic [4:0]  obs_rd  [16];
  logic [31:0] obs_dat [16];
  logic        pv_stall = 1'b0;
  logic [4:0]  pv_rd;
  logic [31:0] pv_dat;

  function automatic void clear_obs();
    obs_n = 0; wbv_n = 0; done_n = 0; terr_n = 0; urst_n = 0;
    done_cyc = -1; terr_cyc = -1; urst_cyc = -1; hs_cyc = -1;
    for (int u = 0; u < N; u++) pop_cnt[u] = 0;
  endfunction

  // one clock: inputs already set; sample at negedge, then move past posedge
  task automatic cycle();
    logic [3:0] pop;
    drive_fifo();
    @(negedge clk);
    cyc++;
    pop = bus.io_fifo_pop;
    check_val("pop_without_valid", pop & ~bus.io_unit_data_valid_out, 0);
    if (pv_stall) begin
      check_val("wb_hold_valid", bus.wb_valid, 1);
      check_val("wb_hold_rd", bus.wb_rd, pv_rd);
      check_val("wb_hold_data", bus.wb_data, pv_dat);
    end
    pv_stall = bus.wb_valid && !bus.wb_ready && !bus.abort;
    pv_rd    = bus.wb_rd;
    pv_dat   = bus.wb_data;
    if (bus.wb_valid) wbv_n++;
    if (bus.wb_valid && bus.wb_ready) begin
      if (obs_n < 16) begin
        obs_rd[obs_n]  = bus.wb_rd;
        obs_dat[obs_n] = bus.wb_data;
      end
      obs_n++;
      hs_cyc = cyc;
    end
    if (bus.done)         begin done_n++; done_cyc = cyc; end
    if (bus.timeout_err)  begin terr_n++; terr_cyc = cyc; end
    if (bus.io_units_rst) begin urst_n++; urst_cyc = cyc; end
    for (int u = 0; u < N; u++) begin
      if (pop[u]) begin
        pop_cnt[u]++;
        if (fifo_cnt[u] > 0) begin
          for (int k = 0; k < 7; k++) fifo_mem[u][k] = fifo_mem[u][k+1];
          fifo_cnt[u]--;
        end
      end
    end
    if (bus.io_units_rst) for (int u = 0; u < N; u++) fifo_cnt[u] = 0;
    @(posedge clk);
    #1;
    drive_fifo();
  endtask

  // full sequence expected to end in done; fast = data preloaded and wb_ready tied high
  task automatic run_seq(input logic [3:0] mask, input logic [3:0][4:0] rds,
                         input logic [3:0][31:0] dat, input bit fast);
    int arr [N];
    int t_start;
    int k;
    clear_obs();
    for (int u = 0; u < N; u++) begin
      arr[u] = fast ? 0 : $urandom_range(0, 5);
      if (!mask[u] && $urandom_range(0, 1) == 1) push(u, $urandom);
    end
    bus.wb_unit_mask = mask;
    bus.wb_rd_addrs  = rds;
    bus.start        = 1'b1;
    bus.abort        = 1'b0;
    t_start          = 0;
    for (int rel = 0; rel < 100; rel++) begin
      for (int u = 0; u < N; u++) if (mask[u] && arr[u] == rel) push(u, dat[u]);
      bus.wb_ready = fast ? 1'b1 : ($urandom_range(0, 99) < 60);
      if (rel > 0) begin
        bus.start        = bus.busy && ($urandom_range(0, 7) == 0);
        bus.wb_unit_mask = 4'($urandom);
        bus.wb_rd_addrs  = 20'($urandom);
      end
      cycle();
      if (rel == 0) t_start = cyc;
      if (!bus.busy) break;
    end
    bus.start = 1'b0;
    check_val("seq_returns_idle", bus.busy, 0);
    k = 0;
    for (int u = 0; u < N; u++) begin
      if (mask[u]) begin
        check_val("wb_rd_order", obs_rd[k], rds[u]);
        check_val("wb_data_order", obs_dat[k], dat[u]);
        k++;
      end
      check_val("pop_once", pop_cnt[u], mask[u]);
    end
    check_val("wb_count", obs_n, k);
    check_val("done_pulses", done_n, 1);
    check_val("no_timeout", terr_n, 0);
    check_val("units_rst_pulses", urst_n, 1);
    check_val("units_rst_with_done", urst_cyc, done_cyc);
    if (fast) begin
      check_val("fast_done_latency", done_cyc - t_start, 2 * k + 1);
      check_val("fast_wb_cycles", wbv_n, k);
    end
  endtask

  // unit 2 never delivers; lower units in mask are preloaded
  task automatic run_timeout(input logic [3:0] mask);
    int t_start;
    int ref_cyc;
    clear_obs();
    for (int u = 0; u < 2; u++) if (mask[u]) push(u, $urandom);
    bus.wb_unit_mask = mask;
    bus.wb_rd_addrs  = 20'($urandom);
    bus.wb_ready     = 1'b1;
    bus.start        = 1'b1;
    cycle();
    t_start   = cyc;
    bus.start = 1'b0;
    for (int i = 0; i < 40; i++) begin
      cycle();
      if (!bus.busy) break;
    end
    ref_cyc = (mask[1:0] != 2'b00) ? hs_cyc : t_start;
    check_val("timeout_pulses", terr_n, 1);
    check_val("timeout_latency", terr_cyc - ref_cyc, TO + 1);
    check_val("timeout_units_rst", urst_cyc, terr_cyc);
    check_val("timeout_no_done", done_n, 0);
    check_val("timeout_unit2_no_pop", pop_cnt[2], 0);
    check_val("timeout_unit3_no_pop", pop_cnt[3], 0);
    check_val("timeout_busy_drops", cyc, terr_cyc);
    check_val("timeout_wb_count", obs_n, mask[0] + mask[1]);
  endtask

  initial begin
    logic [3:0][4:0]  rds;
    logic [3:0][31:0] dat;
    int t0, t_rdy, ab_cyc;

    for (int u = 0; u < N; u++) fifo_cnt[u] = 0;
    bus.start = 1'b0; bus.abort = 1'b0; bus.wb_ready = 1'b0;
    bus.wb_unit_mask = '0; bus.wb_rd_addrs = '0;
    drive_fifo();
    rst = 1'b1;
    #1 rst = 1'b0;
    #1;
    check_val("rst_busy", bus.busy, 0);
    check_val("rst_wb_valid", bus.wb_valid, 0);
    check_val("rst_wb_rd", bus.wb_rd, 0);
    check_val("rst_wb_data", bus.wb_data, 0);
    check_val("rst_pop", bus.io_fifo_pop, 0);
    check_val("rst_done", bus.done, 0);
    check_val("rst_timeout", bus.timeout_err, 0);
    check_val("rst_units_rst", bus.io_units_rst, 0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;

    // mask 0b1011, rd {5,7,-,9}, data A,B,-,D
    rds = '0; dat = '0;
    rds[0] = 5'd5; rds[1] = 5'd7; rds[3] = 5'd9;
    dat[0] = 32'hA; dat[1] = 32'hB; dat[3] = 32'hD;
    run_seq(4'b1011, rds, dat, 1'b1);

    // empty mask
    run_seq(4'b0000, rds, dat, 1'b1);

    // single unit, consumer stalls 5 cycles
    clear_obs();
    push(0, 32'h1234_5678);
    bus.wb_unit_mask = 4'b0001; rds = '0; rds[0] = 5'd17; bus.wb_rd_addrs = rds;
    bus.wb_ready = 1'b0; bus.start = 1'b1;
    cycle();
    bus.start = 1'b0;
    cycle();
    repeat (5) cycle();
    bus.wb_ready = 1'b1;
    cycle();
    t_rdy = cyc;
    bus.wb_ready = 1'b0;
    cycle();
    check_val("stall_done_after_ready", done_cyc, t_rdy + 1);
    check_val("stall_wb_cycles", wbv_n, 6);
    check_val("stall_single_pop", pop_cnt[0], 1);
    check_val("stall_wb_data", obs_dat[0], 32'h1234_5678);
    check_val("stall_wb_rd", obs_rd[0], 17);

    // timeouts: first unit and after an earlier writeback
    run_timeout(4'b0100);
    run_timeout(4'b1110);

    // abort in WB of the second of three units, consumer accepting that cycle
    clear_obs();
    push(0, 32'h100); push(1, 32'h101); push(2, 32'h102);
    rds = '0; rds[0] = 5'd3; rds[1] = 5'd4; rds[2] = 5'd6;
    bus.wb_unit_mask = 4'b0111; bus.wb_rd_addrs = rds;
    bus.wb_ready = 1'b0; bus.start = 1'b1;
    cycle();
    bus.start = 1'b0;
    ab_cyc = -1;
    for (int i = 0; i < 40; i++) begin
      bus.abort    = (ab_cyc < 0) && bus.wb_valid && (bus.wb_rd == 5'd4);
      bus.wb_ready = bus.wb_valid && (bus.wb_rd == 5'd3 || bus.wb_rd == 5'd4);
      cycle();
      if (bus.abort) ab_cyc = cyc;
      bus.abort = 1'b0;
      if (!bus.busy) break;
    end
    check_val("abort_wb_flush_next", urst_cyc, ab_cyc + 1);
    check_val("abort_wb_no_done", done_n, 0);
    check_val("abort_wb_no_timeout", terr_n, 0);
    check_val("abort_wb_handshakes", obs_n, 2);
    check_val("abort_wb_second_rd", obs_rd[1], 4);
    check_val("abort_wb_third_no_pop", pop_cnt[2], 0);

    // abort and start together in IDLE: start dropped
    bus.start = 1'b1; bus.abort = 1'b1; bus.wb_unit_mask = 4'b0001;
    cycle();
    check_val("idle_abort_drops_start", bus.busy, 0);
    bus.start = 1'b0; bus.abort = 1'b0;

    // abort in COLLECT while data valid: the pop still happens
    clear_obs();
    push(0, 32'h200); push(1, 32'h201);
    rds = '0; rds[0] = 5'd1; rds[1] = 5'd2;
    bus.wb_unit_mask = 4'b0011; bus.wb_rd_addrs = rds;
    bus.wb_ready = 1'b1; bus.start = 1'b1;
    cycle();
    bus.start = 1'b0;
    ab_cyc = -1;
    for (int i = 0; i < 40; i++) begin
      bus.abort = (ab_cyc < 0) && bus.io_fifo_pop[1];
      cycle();
      if (bus.abort) ab_cyc = cyc;
      bus.abort = 1'b0;
      if (!bus.busy) break;
    end
    check_val("abort_col_pop", pop_cnt[1], 1);
    check_val("abort_col_wb_count", obs_n, 1);
    check_val("abort_col_flush_next", urst_cyc, ab_cyc + 1);
    check_val("abort_col_no_done", done_n, 0);
    check_val("abort_col_no_timeout", terr_n, 0);

    // reset mid-COLLECT
    clear_obs();
    bus.wb_unit_mask = 4'b0001; bus.start = 1'b1;
    cycle();
    bus.start = 1'b0;
    cycle(); cycle();
    check_val("busy_before_reset", bus.busy, 1);
    #2 rst = 1'b0;
    push(0, 32'hCAFE);
    drive_fifo();
    #1;
    check_val("async_rst_busy", bus.busy, 0);
    check_val("async_rst_pop", bus.io_fifo_pop, 0);
    check_val("async_rst_wb_valid", bus.wb_valid, 0);
    check_val("async_rst_units_rst", bus.io_units_rst, 0);
    check_val("async_rst_timeout", bus.timeout_err, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    for (int u = 0; u < N; u++) fifo_cnt[u] = 0;
    pv_stall = 1'b0;
    drive_fifo();

    // randomized sequences
    for (int s = 0; s < 24; s++) begin
      for (int u = 0; u < N; u++) begin
        rds[u] = 5'($urandom);
        dat[u] = $urandom;
      end
      run_seq(4'($urandom), rds, dat, (s % 2) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
